// File: rtl/iob_spi_flash_resp_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states and
// status register layout.
package iob_spi_flash_resp_pkg;

    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_RDID = 8'h9F;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_PP_DATA,
        ST_STATUS,
        ST_ID,
        ST_IGNORE
    } state_t;

    // WIP is always zero: writes complete instantly in the backing memory.
    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] s;
        s         = 8'h00;
        s[SR_WEL] = wel;
        s[SR_WIP] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/iob_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by an edge detector
// that emits one-cycle rise and fall pulses.
module iob_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic arst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    // sh[1:0] synchronize, sh[2] holds the previous synchronized value.
    logic [2:0] sh;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sh <= {3{RST_VAL}};
        end else if (cke_i) begin
            sh <= {sh[1:0], d_i};
        end
    end

    assign rise_o = sh[1] & ~sh[2];
    assign fall_o = ~sh[1] & sh[2];

endmodule

// File: rtl/iob_spi_flash_resp.sv
// Mode-0 SPI flash responder answering a subset of the N25Q command set from
// an external byte-wide synchronous memory; SCLK is oversampled by clk_i.
module iob_spi_flash_resp
    import iob_spi_flash_resp_pkg::*;
#(
    parameter int          MEM_ADDR_W = 16,
    parameter logic [23:0] JEDEC_ID   = 24'h20BA18
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  ss_n_i,
    input  logic                  sclk_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic [7:0]            mem_rdata_i,
    output logic                  wel_o
);

    logic        ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [1:0]  mosi_s;
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt;
    logic [1:0]  abyte_cnt;
    logic [6:0]  in_shift;
    logic [7:0]  cmd_q;
    logic [23:0] addr_q;
    logic [7:0]  out_byte;
    logic [1:0]  id_idx;
    logic        wel_q, pp_any, rd_pend;
    logic [7:0]  in_byte;
    logic        byte_done;
    logic [23:0] addr_shift, addr_inc;

    iob_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .d_i(ss_n_i),
        .rise_o(ss_rise), .fall_o(ss_fall)
    );

    iob_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i), .d_i(sclk_i),
        .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    // MOSI has the same two-flop delay as SCLK, so it is sampled in step.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) mosi_s <= 2'b00;
        else if (cke_i) mosi_s <= {mosi_s[0], mosi_i};
    end

    assign in_byte    = {in_shift, mosi_s[1]};
    assign byte_done  = sclk_rise && (bit_cnt == 3'd7) && !ss_rise && (state_q != ST_IDLE);
    assign addr_shift = {addr_q[15:0], in_byte};
    assign addr_inc   = addr_q + 24'd1;
    assign wel_o      = wel_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state_q <= ST_IDLE;
        else if (cke_i) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ss_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (ss_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        case (in_byte)
                            CMD_READ, CMD_PP: state_d = ST_ADDR;
                            CMD_RDSR:         state_d = ST_STATUS;
                            CMD_RDID:         state_d = ST_ID;
                            default:          state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (byte_done && abyte_cnt == 2'd2)
                        state_d = (cmd_q == CMD_READ) ? ST_RD_DATA : ST_PP_DATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            miso_o      <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= 8'h00;
            bit_cnt     <= 3'd0;
            abyte_cnt   <= 2'd0;
            in_shift    <= 7'd0;
            cmd_q       <= 8'h00;
            addr_q      <= 24'd0;
            out_byte    <= 8'h00;
            id_idx      <= 2'd0;
            wel_q       <= 1'b0;
            pp_any      <= 1'b0;
            rd_pend     <= 1'b0;
        end else if (cke_i) begin
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            rd_pend  <= mem_en_o & ~mem_we_o;
            if (rd_pend && state_q == ST_RD_DATA) out_byte <= mem_rdata_i;

            if (ss_rise) begin
                // Deselect wins over any byte completing in the same cycle.
                if (state_q == ST_PP_DATA && pp_any) wel_q <= 1'b0;
                bit_cnt   <= 3'd0;
                abyte_cnt <= 2'd0;
                pp_any    <= 1'b0;
                addr_q    <= 24'd0;
                out_byte  <= 8'h00;
                miso_o    <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                if (ss_fall) begin
                    bit_cnt  <= 3'd0;
                    out_byte <= 8'h00;
                    miso_o   <= 1'b0;
                end
            end else begin
                if (sclk_rise) begin
                    in_shift <= in_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state_q)
                        ST_CMD: begin
                            cmd_q     <= in_byte;
                            abyte_cnt <= 2'd0;
                            out_byte  <= 8'h00;
                            case (in_byte)
                                CMD_WREN: wel_q <= 1'b1;
                                CMD_WRDI: wel_q <= 1'b0;
                                CMD_RDSR: out_byte <= status_byte(wel_q);
                                CMD_RDID: begin
                                    out_byte <= JEDEC_ID[23:16];
                                    id_idx   <= 2'd1;
                                end
                                default: ;
                            endcase
                        end
                        ST_ADDR: begin
                            addr_q    <= addr_shift;
                            abyte_cnt <= abyte_cnt + 2'd1;
                            if (abyte_cnt == 2'd2 && cmd_q == CMD_READ) begin
                                mem_en_o   <= 1'b1;
                                mem_addr_o <= addr_shift[MEM_ADDR_W-1:0];
                            end
                        end
                        ST_RD_DATA: begin
                            addr_q     <= addr_inc;
                            mem_en_o   <= 1'b1;
                            mem_addr_o <= addr_inc[MEM_ADDR_W-1:0];
                        end
                        ST_PP_DATA: begin
                            pp_any      <= 1'b1;
                            addr_q[7:0] <= addr_q[7:0] + 8'd1;
                            if (wel_q) begin
                                mem_en_o    <= 1'b1;
                                mem_we_o    <= 1'b1;
                                mem_addr_o  <= addr_q[MEM_ADDR_W-1:0];
                                mem_wdata_o <= in_byte;
                            end
                        end
                        ST_STATUS: out_byte <= status_byte(wel_q);
                        ST_ID: begin
                            case (id_idx)
                                2'd1:    out_byte <= JEDEC_ID[15:8];
                                2'd2:    out_byte <= JEDEC_ID[7:0];
                                default: out_byte <= 8'h00;
                            endcase
                            if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        end
                        default: out_byte <= 8'h00;
                    endcase
                end
                // bit_cnt counts received bits, so ~bit_cnt selects the next MSB-first bit.
                if (sclk_fall) miso_o <= out_byte[~bit_cnt];
            end
        end
    end

endmodule
